// File: rtl/gs_pkg.sv
// Shared types for the Goldschmidt divider controller: FSM states and
// multiplier operand select encodings.
package gs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_N = 2'd1,
        MUL_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_D    = 2'd0;
    localparam logic [1:0] SEL_N    = 2'd1;
    localparam logic [1:0] SEL_NEWD = 2'd2;
    localparam logic [1:0] SEL_NEWN = 2'd3;

    localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/gs_iter_cnt.sv
// Iteration counter: synchronous clear/increment with a terminal-count flag.
// The next count is exported so the controller can register its outputs.
module gs_iter_cnt
    import gs_pkg::*;
#(
    parameter int unsigned LAST = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign tc = (cnt == CNT_W'(LAST));

endmodule

// File: rtl/gs_div_ctrl.sv
// Goldschmidt division sequencer: alternates N/D scaling for ITERS iterations.
// Optional macro GS_ABORT_EN adds an abort input honoured in the MUL states.
module gs_div_ctrl
    import gs_pkg::*;
#(
    parameter int unsigned ITERS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef GS_ABORT_EN
    input  logic       abort,
`endif
    output logic       kSelect,
    output logic [1:0] ndSelect,
    output logic       nEnable,
    output logic       dEnable,
    output logic       busy,
    output logic       done
);

    state_t           state;
    state_t           state_nxt;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             tc;
    logic [CNT_W-1:0] cnt_nxt;
    logic             abort_hit;
    logic             k_nxt;
    logic [1:0]       nd_nxt;

`ifdef GS_ABORT_EN
    assign abort_hit = abort && (state == MUL_N || state == MUL_D);
`else
    assign abort_hit = 1'b0;
`endif

    gs_iter_cnt #(
        .LAST (ITERS - 1)
    ) u_iter_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .cnt_nxt (cnt_nxt),
        .tc      (tc)
    );

    // Next state and counter control; abort overrides the normal transition
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MUL_N;
                    cnt_clr   = 1'b1;
                end
            end
            MUL_N: state_nxt = MUL_D;
            MUL_D: begin
                if (tc) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = MUL_N;
                    cnt_inc   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = IDLE;
            cnt_inc   = 1'b0;
            cnt_clr   = 1'b1;
        end
    end

    // Operand selects for the upcoming state; iteration 0 uses the raw inputs
    always_comb begin
        k_nxt  = 1'b0;
        nd_nxt = SEL_D;
        case (state_nxt)
            MUL_N: begin
                k_nxt  = (cnt_nxt != '0);
                nd_nxt = (cnt_nxt != '0) ? SEL_NEWN : SEL_N;
            end
            MUL_D: begin
                k_nxt  = (cnt_nxt != '0);
                nd_nxt = (cnt_nxt != '0) ? SEL_NEWD : SEL_D;
            end
            default: begin
                k_nxt  = 1'b0;
                nd_nxt = SEL_D;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            kSelect  <= 1'b0;
            ndSelect <= SEL_D;
            nEnable  <= 1'b0;
            dEnable  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            kSelect  <= k_nxt;
            ndSelect <= nd_nxt;
            nEnable  <= (state_nxt == MUL_N);
            dEnable  <= (state_nxt == MUL_D);
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_gs_div_ctrl.sv
// Scoreboard bench for gs_div_ctrl: ITERS=3 and ITERS=1 instances share stimulus.
// Build with GS_ABORT_EN defined to exercise the abort input.
module tb_gs_div_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
`ifdef GS_ABORT_EN
    logic abort = 1'b0;
`endif

    logic       k3, ne3, de3, b3, d3;
    logic [1:0] nd3;
    logic       k1, ne1, de1, b1, d1;
    logic [1:0] nd1;
    logic [6:0] v3, v1;

    // Output tuple layout: {kSelect, ndSelect[1:0], nEnable, dEnable, busy, done}
    assign v3 = {k3, nd3, ne3, de3, b3, d3};
    assign v1 = {k1, nd1, ne1, de1, b1, d1};

    always #5 clk = ~clk;

    gs_div_ctrl #(.ITERS(3)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef GS_ABORT_EN
        .abort    (abort),
`endif
        .kSelect  (k3),
        .ndSelect (nd3),
        .nEnable  (ne3),
        .dEnable  (de3),
        .busy     (b3),
        .done     (d3)
    );

    gs_div_ctrl #(.ITERS(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef GS_ABORT_EN
        .abort    (abort),
`endif
        .kSelect  (k1),
        .ndSelect (nd1),
        .nEnable  (ne1),
        .dEnable  (de1),
        .busy     (b1),
        .done     (d1)
    );

    int errs   = 0;
    int checks = 0;

    logic [6:0] q3[$];
    logic [6:0] q1[$];
    logic [6:0] cur3 = '0;
    logic [6:0] cur1 = '0;
    logic [6:0] exp3, exp1;
    logic       ab3, ab1;

    // Expected output for cycle j of a division: N/D pairs, then done, then idle
    function automatic logic [6:0] seq_item(input int iters, input int j);
        logic [6:0] r;
        int         it;
        logic       isn;
        r = '0;
        if (j < 2 * iters) begin
            it     = j / 2;
            isn    = (j % 2 == 0);
            r[6]   = (it > 0);
            r[5:4] = isn ? ((it > 0) ? 2'd3 : 2'd1) : ((it > 0) ? 2'd2 : 2'd0);
            r[3]   = isn;
            r[2]   = !isn;
            r[1]   = 1'b1;
        end else if (j == 2 * iters) begin
            r = 7'b0000011;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
        end
    endtask

    // Reference model: accept start only when no division is outstanding
    always @(posedge clk) begin
        ab3 = 1'b0;
        ab1 = 1'b0;
`ifdef GS_ABORT_EN
        ab3 = abort && (cur3[3] || cur3[2]);
        ab1 = abort && (cur1[3] || cur1[2]);
`endif
        if (reset) begin
            q3.delete();
            q1.delete();
        end else begin
            if (ab3) q3.delete();
            else if (q3.size() == 0 && start)
                for (int j = 0; j < 2 * 3 + 2; j++) q3.push_back(seq_item(3, j));
            if (ab1) q1.delete();
            else if (q1.size() == 0 && start)
                for (int j = 0; j < 2 * 1 + 2; j++) q1.push_back(seq_item(1, j));
        end
    end

    // Monitor: async reset check while clk is high, scoreboard compare on negedge
    always @(negedge clk or posedge reset) begin
        if (clk) begin
            #1;
            check("async_reset_iters3", v3, 7'd0);
            check("async_reset_iters1", v1, 7'd0);
            cur3 = '0;
            cur1 = '0;
        end else begin
            if (reset)             exp3 = '0;
            else if (q3.size() > 0) exp3 = q3.pop_front();
            else                   exp3 = '0;
            if (reset)             exp1 = '0;
            else if (q1.size() > 0) exp1 = q1.pop_front();
            else                   exp1 = '0;
            cur3 = exp3;
            cur1 = exp1;
            check("outputs_iters3", v3, exp3);
            check("outputs_iters1", v1, exp1);
            check("enable_excl_iters3", {6'd0, ne3 & de3}, 7'd0);
            check("enable_excl_iters1", {6'd0, ne1 & de1}, 7'd0);
        end
    end

    task automatic async_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #7 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single start pulse
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Start held high: back-to-back divisions
        start = 1'b1;
        repeat (40) @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        // Reset in cycle 4 of a division, then restart immediately
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        async_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

`ifdef GS_ABORT_EN
        // Abort in MUL_D of iteration 1, then abort while idle
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            start = ($urandom % 3 == 0);
`ifdef GS_ABORT_EN
            abort = ($urandom % 12 == 0);
`endif
            if ($urandom % 90 == 0) async_reset();
            else @(negedge clk);
        end
        start = 1'b0;
`ifdef GS_ABORT_EN
        abort = 1'b0;
`endif
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/gs_div_ctrl.md
GS_DIV_CTRL -- requirements
Module: gs_div_ctrl

Interface
REQ-001 Parameter ITERS, default 3, number of Goldschmidt iterations per division; legal range 1..7.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  request a new division; sampled only in IDLE.
REQ-005 kSelect  output  1  0 = K from IA, 1 = K from previous iterate (kGenerator select).
REQ-006 ndSelect  output  2  multiplier operand select: 0 = D, 1 = N, 2 = newD, 3 = newN.
REQ-007 nEnable  output  1  load enable for the N iterate register.
REQ-008 dEnable  output  1  load enable for the D iterate register.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse; result is valid on the datapath in this cycle.

Function
REQ-011 FSM states: IDLE, MUL_N, MUL_D, DONE; all outputs are Moore, decoded from state and iteration count only.
REQ-012 IDLE: if start=1 at an edge, go to MUL_N and clear iteration counter to 0; otherwise stay.
REQ-013 MUL_N: nEnable=1, dEnable=0; next state MUL_D.
REQ-014 MUL_D: dEnable=1, nEnable=0; if counter = ITERS-1 go to DONE, else increment counter and go to MUL_N.
REQ-015 N is always scaled before D within an iteration, so K derived from the current D stays valid for both products.
REQ-016 Iteration 0: kSelect=0, ndSelect=1 in MUL_N, ndSelect=0 in MUL_D.
REQ-017 Iterations 1..ITERS-1: kSelect=1, ndSelect=3 in MUL_N, ndSelect=2 in MUL_D.
REQ-018 DONE: done=1, busy=1, both enables 0; next state IDLE unconditionally.
REQ-019 In IDLE and DONE: kSelect=0, ndSelect=0, nEnable=0, dEnable=0.
REQ-020 Latency: start sampled at edge E0 -> done high for the cycle after edge E0+2*ITERS (cycle 7 for ITERS=3).
REQ-021 Throughput: a new start is accepted no earlier than the cycle after done (IDLE); start in any non-IDLE state is ignored, not queued.
REQ-022 Exactly one of nEnable/dEnable is high in MUL states; never both high in any state.
REQ-023 Iteration counter is 3 bits; it never wraps because it is bounded by ITERS-1.

Reset
REQ-024 Reset forces state IDLE, counter 0, and all outputs 0 (kSelect, ndSelect, nEnable, dEnable, busy, done), asynchronously.
REQ-025 Reset asserted mid-division aborts it; no done pulse is produced for the aborted operation.
REQ-026 After reset deasserts, start is honoured at the first rising edge.

Configuration
REQ-027 Macro GS_ABORT_EN: when defined, adds input abort (1 bit); abort=1 at an edge in MUL_N or MUL_D forces IDLE with no done pulse; abort has priority over the normal transition; abort is ignored in IDLE and DONE.
REQ-028 Without GS_ABORT_EN, the abort port does not exist and the behaviour is exactly REQ-011..REQ-023.

Structure
REQ-029 Shared package gs_pkg holds the state enum typedef and the ndSelect encoding constants (SEL_D, SEL_N, SEL_NEWD, SEL_NEWN).
REQ-030 The sub-module gs_iter_cnt (3-bit clear/increment counter with terminal-count output) is used; all other logic is inline.

Verification
REQ-031 Reset, then start=1 for 1 cycle with ITERS=3 -> enables N,D,N,D,N,D in cycles 1-6, ndSelect 1,0,3,2,3,2, kSelect 0,0,1,1,1,1, done=1 in cycle 7 only.
REQ-032 ITERS=1, start pulse -> MUL_N (ndSelect=1), MUL_D (ndSelect=0), done in cycle 3, busy low in cycle 4.
REQ-033 start held high continuously, ITERS=3 -> second division begins at the first edge in IDLE after done; done pulses every 8 cycles.
REQ-034 Assert reset asynchronously in cycle 4 of a division -> all outputs 0 before the next edge, no done, next start works normally.
REQ-035 GS_ABORT_EN defined: abort=1 in MUL_D of iteration 1 -> IDLE at the next edge, no done; abort=1 in IDLE -> no effect.
REQ-036 Every cycle, check nEnable & dEnable == 0 and busy == (state != IDLE).
